// File: rtl/vec_operand_sequencer_if.sv
// vec_operand_sequencer_if: command, register-file and ALU signal bundle for the operand sequencer.
// slave = the sequencer itself; master = the environment (command source, RF, ALU).
// The ALU-side vap copy is named alu_vap because vap is already taken by the command input.
interface vec_operand_sequencer_if;
  // command and status
  logic         start;
  logic [7:0]   instr;
  logic [9:0]   sew;
  logic [3:0]   vap;
  logic [4:0]   vs1;
  logic [4:0]   vs2;
  logic [4:0]   vd;
  logic         busy;
  logic         done;
  // register-file read port (data one cycle after address)
  logic [4:0]   rf_raddr;
  logic [1:0]   rf_rword;
  logic [31:0]  rf_rdata;
  // register-file write port
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [1:0]   rf_wword;
  logic [31:0]  rf_wdata;
  // ALU side
  logic [7:0]   micro_exec_instr;
  logic [9:0]   SEW;
  logic [3:0]   alu_vap;
  logic [127:0] opA;
  logic [127:0] opB;
  logic [127:0] opC;
  logic         alu_start;
  logic [127:0] alu_out;
  logic         alu_done;

  modport slave (
    input  start, instr, sew, vap, vs1, vs2, vd,
    input  rf_rdata, alu_out, alu_done,
    output busy, done,
    output rf_raddr, rf_rword,
    output rf_we, rf_waddr, rf_wword, rf_wdata,
    output micro_exec_instr, SEW, alu_vap, opA, opB, opC, alu_start
  );

  modport master (
    output start, instr, sew, vap, vs1, vs2, vd,
    output rf_rdata, alu_out, alu_done,
    input  busy, done,
    input  rf_raddr, rf_rword,
    input  rf_we, rf_waddr, rf_wword, rf_wdata,
    input  micro_exec_instr, SEW, alu_vap, opA, opB, opC, alu_start
  );
endinterface

// File: rtl/vec_operand_sequencer.sv
// vec_operand_sequencer: reads vector operands word by word, launches the ALU, writes the result to vd.
// Latency start->done: (reads+1) READ + 1 ISSUE + ALU cycles in WAIT + NWORDS WB + 1 DONE.
// Backpressure: start ignored while busy; WAIT holds until alu_done. Option macro: VOS_SAME_REG_BYPASS_EN.
module vec_operand_sequencer #(
  parameter int NWORDS = 4
) (
  input logic                    clk,
  input logic                    reset,
  vec_operand_sequencer_if.slave bus
);
  localparam int WW = $clog2(NWORDS);
  localparam int CW = $clog2(3 * NWORDS + 1);
  localparam int VW = 32 * NWORDS;

  // operand slot codes
  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;

  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, WB, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      instr_q, instr_d;
  logic [9:0]      sew_q, sew_d;
  logic [3:0]      vap_q, vap_d;
  logic [4:0]      vs1_q, vs1_d;
  logic [4:0]      vs2_q, vs2_d;
  logic [4:0]      vd_q, vd_d;
  logic            three_q, three_d;
  logic            skip_b_q, skip_b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   opa_q, opa_d;
  logic [VW-1:0]   opb_q, opb_d;
  logic [VW-1:0]   opc_q, opc_d;
  logic [VW-1:0]   res_q, res_d;

  logic [CW-1:0]   n_reads;
  logic [CW-1:0]   cap_idx;
  logic [1:0]      rd_op;
  logic [1:0]      cap_op;
  logic [WW-1:0]   rd_word;
  logic [WW-1:0]   cap_word;

  // Map a read-slot position (0,1,2) to the operand it fills; B is skipped when bypassed.
  function automatic logic [1:0] slot_op(input logic [1:0] pos, input logic skip);
    return (skip && pos != 2'd0) ? pos + 2'd1 : pos;
  endfunction

  // Number of reads for the latched command, and which operand/word the counter addresses
  // (rd_* for the address issued now, cap_* for the data returning now).
  always_comb begin
    n_reads  = CW'(NWORDS * ((three_q ? 3 : 2) - (skip_b_q ? 1 : 0)));
    cap_idx  = cnt_q - CW'(1);
    rd_op    = slot_op(2'(cnt_q / CW'(NWORDS)), skip_b_q);
    rd_word  = WW'(cnt_q % CW'(NWORDS));
    cap_op   = slot_op(2'(cap_idx / CW'(NWORDS)), skip_b_q);
    cap_word = WW'(cap_idx % CW'(NWORDS));
  end

  // Next-state logic, operand assembly and the RF/ALU/status outputs.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    sew_d    = sew_q;
    vap_d    = vap_q;
    vs1_d    = vs1_q;
    vs2_d    = vs2_q;
    vd_d     = vd_q;
    three_d  = three_q;
    skip_b_d = skip_b_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opc_d    = opc_q;
    res_d    = res_q;

    bus.busy      = (state_q != IDLE);
    bus.done      = 1'b0;
    bus.rf_raddr  = 5'd0;
    bus.rf_rword  = 2'd0;
    bus.rf_we     = 1'b0;
    bus.rf_waddr  = 5'd0;
    bus.rf_wword  = 2'd0;
    bus.rf_wdata  = 32'd0;
    bus.alu_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          instr_d = bus.instr;
          sew_d   = bus.sew;
          vap_d   = bus.vap;
          vs1_d   = bus.vs1;
          vs2_d   = bus.vs2;
          vd_d    = bus.vd;
          three_d = (bus.instr == 8'h02) || (bus.instr == 8'h05);
`ifdef VOS_SAME_REG_BYPASS_EN
          skip_b_d = (bus.vs1 == bus.vs2);
`else
          skip_b_d = 1'b0;
`endif
          cnt_d   = '0;
          opa_d   = '0;
          opb_d   = '0;
          opc_d   = '0;
          state_d = READ;
        end
      end

      READ: begin
        // address phase: one word per cycle until all reads are issued
        if (cnt_q < n_reads) begin
          case (rd_op)
            OP_A:    bus.rf_raddr = vs1_q;
            OP_B:    bus.rf_raddr = vs2_q;
            default: bus.rf_raddr = vd_q;
          endcase
          bus.rf_rword = 2'(rd_word);
        end
        // data phase: the word addressed last cycle is on rf_rdata now
        if (cnt_q != '0) begin
          case (cap_op)
            OP_A:    opa_d[32*cap_word +: 32] = bus.rf_rdata;
            OP_B:    opb_d[32*cap_word +: 32] = bus.rf_rdata;
            OP_C:    opc_d[32*cap_word +: 32] = bus.rf_rdata;
            default: ;
          endcase
        end
        if (cnt_q == n_reads) begin
          if (skip_b_q) opb_d = opa_d;
          cnt_d   = '0;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ISSUE: begin
        bus.alu_start = 1'b1;
        state_d       = WAIT;
      end

      WAIT: begin
        if (bus.alu_done) begin
          res_d   = bus.alu_out;
          cnt_d   = '0;
          state_d = WB;
        end
      end

      WB: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = vd_q;
        bus.rf_wword = 2'(cnt_q[WW-1:0]);
        bus.rf_wdata = res_q[32*cnt_q[WW-1:0] +: 32];
        if (cnt_q == CW'(NWORDS - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      sew_q    <= '0;
      vap_q    <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      three_q  <= 1'b0;
      skip_b_q <= 1'b0;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      opc_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      sew_q    <= sew_d;
      vap_q    <= vap_d;
      vs1_q    <= vs1_d;
      vs2_q    <= vs2_d;
      vd_q     <= vd_d;
      three_q  <= three_d;
      skip_b_q <= skip_b_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opc_q    <= opc_d;
      res_q    <= res_d;
    end
  end

  // Operands and command fields are held in registers, so they stay stable through WAIT.
  assign bus.opA              = opa_q;
  assign bus.opB              = opb_q;
  assign bus.opC              = opc_q;
  assign bus.micro_exec_instr = instr_q;
  assign bus.SEW              = sew_q;
  assign bus.alu_vap          = vap_q;
endmodule

// File: tb/tb_vec_operand_sequencer.sv
// tb_vec_operand_sequencer: directed and random commands against a register-file image,
// a behavioural ALU and a reference model of the read order, operands, result and timing.
module tb_vec_operand_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vec_operand_sequencer_if bus();

  vec_operand_sequencer #(.NWORDS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [127:0] mem [32];
  logic [127:0] last_wr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU: per 32-bit element, 01 multiply, 02/05 multiply-accumulate, others add.
  function automatic logic [127:0] alu_ref(input logic [7:0] op, input logic [127:0] a,
                                           input logic [127:0] b, input logic [127:0] c);
    logic [127:0] r;
    logic [31:0]  x, y, z;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      x = a[32*k +: 32];
      y = b[32*k +: 32];
      z = c[32*k +: 32];
      case (op)
        8'h01:        r[32*k +: 32] = x * y;
        8'h02, 8'h05: r[32*k +: 32] = x * y + z;
        default:      r[32*k +: 32] = x + y;
      endcase
    end
    return r;
  endfunction

  task automatic run_cmd(input logic [7:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input int lat, input bit stray, input bit abort,
                         input string tag);
    bit three, skip, aborted, seen_issue;
    int exp_rd[$];
    int got_rd[$];
    int n, alu_due, done_cnt, done_cyc, wr_cnt, bad_wr, bad_rd, late_busy, unstable, extra, pend, exp_done;
    logic [127:0] ea, eb, ec, er, ga, gb, gc, wr_val;
    logic [9:0] sew_v, gs;
    logic [3:0] vap_v, gv;
    logic [7:0] gi;

    three = (op == 8'h02) || (op == 8'h05);
    skip  = 1'b0;
`ifdef VOS_SAME_REG_BYPASS_EN
    skip = (s1 == s2);
`endif
    for (int w = 0; w < 4; w++) exp_rd.push_back(int'(s1) * 4 + w);
    if (!skip) for (int w = 0; w < 4; w++) exp_rd.push_back(int'(s2) * 4 + w);
    if (three) for (int w = 0; w < 4; w++) exp_rd.push_back(int'(d) * 4 + w);
    ea = mem[s1];
    eb = mem[s2];
    ec = three ? mem[d] : 128'd0;
    er = alu_ref(op, ea, eb, ec);
    exp_done = exp_rd.size() + 1 + 1 + lat + 4 + 1;

    n = 0; alu_due = -1; done_cnt = 0; done_cyc = -1; wr_cnt = 0; bad_wr = 0; bad_rd = 0;
    late_busy = 0; unstable = 0; extra = 0; pend = 0; aborted = 0; seen_issue = 0;
    wr_val = '0; ga = '0; gb = '0; gc = '0; gi = '0; gs = '0; gv = '0;
    sew_v = 10'($urandom);
    vap_v = 4'($urandom);
    bus.instr = op; bus.sew = sew_v; bus.vap = vap_v;
    bus.vs1 = s1; bus.vs2 = s2; bus.vd = d;

    while (n < 300) begin
      if (bus.alu_start && !seen_issue) begin
        seen_issue = 1; ga = bus.opA; gb = bus.opB; gc = bus.opC;
        gi = bus.micro_exec_instr; gs = bus.SEW; gv = bus.alu_vap;
        alu_due = n + lat;
      end
      if (seen_issue && n <= alu_due &&
          ({bus.opA, bus.opB, bus.opC} !== {ga, gb, gc} || bus.micro_exec_instr !== gi ||
           bus.SEW !== gs || bus.alu_vap !== gv)) unstable++;
      if (!seen_issue && bus.rf_raddr != 5'd0)
        got_rd.push_back(int'(bus.rf_raddr) * 4 + int'(bus.rf_rword));
      if (bus.rf_we) begin
        if (bus.rf_waddr !== d || int'(bus.rf_wword) != wr_cnt) bad_wr++;
        wr_val[32*bus.rf_wword +: 32] = bus.rf_wdata;
        wr_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (done_cyc >= 0 && n > done_cyc && bus.busy) late_busy++;
      if (abort && wr_cnt == 2) begin
        aborted = 1;
        break;
      end
      if (done_cyc >= 0 && n >= done_cyc + 3) break;

      bus.start    = (n == 0) || (stray && (n == 2 || (alu_due >= 0 && n == alu_due - 1) || n == done_cyc));
      bus.alu_done = (n == alu_due) || (stray && n == 3);
      bus.alu_out  = (n == alu_due) ? alu_ref(gi, ga, gb, gc) : {$urandom, $urandom, $urandom, $urandom};
      pend = int'(bus.rf_raddr) * 4 + int'(bus.rf_rword);
      @(posedge clk);
      #1;
      bus.rf_rdata = mem[pend / 4][32 * (pend % 4) +: 32];
      n++;
    end
    bus.start    = 1'b0;
    bus.alu_done = 1'b0;

    if (abort) begin
      chk({tag, "_abort_reached"}, aborted, 1);
      reset = 1'b1;
      #1;
      chk({tag, "_abort_we"}, bus.rf_we, 0);
      chk({tag, "_abort_busy"}, bus.busy, 0);
      chk({tag, "_abort_done"}, bus.done, 0);
      chk({tag, "_abort_opA"}, bus.opA, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (6) begin
        if (bus.rf_we || bus.done || bus.busy) extra++;
        @(posedge clk);
        #1;
      end
      chk({tag, "_abort_quiet"}, extra, 0);
      mem[d][63:0] = er[63:0];
      return;
    end

    for (int i = 0; i < exp_rd.size(); i++)
      if (i >= got_rd.size() || got_rd[i] != exp_rd[i]) bad_rd++;
    chk({tag, "_nreads"}, got_rd.size(), exp_rd.size());
    chk({tag, "_read_order"}, bad_rd, 0);
    chk({tag, "_opA"}, ga, ea);
    chk({tag, "_opB"}, gb, eb);
    chk({tag, "_opC"}, gc, ec);
    chk({tag, "_instr"}, gi, op);
    chk({tag, "_sew_vap"}, {gs, gv}, {sew_v, vap_v});
    chk({tag, "_stable"}, unstable, 0);
    chk({tag, "_wr_cnt"}, wr_cnt, 4);
    chk({tag, "_wr_addr"}, bad_wr, 0);
    chk({tag, "_wr_data"}, wr_val, er);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_latency"}, done_cyc, exp_done);
    chk({tag, "_idle_after"}, late_busy, 0);
    last_wr = wr_val;
    mem[d] = er;
  endtask

  initial begin
    logic [7:0] ops [5];
    logic [4:0] r1, r2, rd;
    ops = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h07};
    reset = 1'b1;
    bus.start = 1'b0; bus.instr = '0; bus.sew = '0; bus.vap = '0;
    bus.vs1 = '0; bus.vs2 = '0; bus.vd = '0;
    bus.rf_rdata = '0; bus.alu_out = '0; bus.alu_done = 1'b0;
    last_wr = '0;
    for (int r = 0; r < 32; r++) mem[r] = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_alu_start", bus.alu_start, 0);
    chk("rst_raddr", {bus.rf_raddr, bus.rf_rword}, 0);
    chk("rst_waddr", {bus.rf_waddr, bus.rf_wword, bus.rf_wdata}, 0);
    chk("rst_ops", {bus.opA, bus.opB, bus.opC}, 0);
    chk("rst_cmd", {bus.micro_exec_instr, bus.SEW, bus.alu_vap}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // vmul with stray start in READ/WAIT/DONE and stray alu_done in READ
    mem[1] = 128'h0000312100001e430000aa2300001111;
    mem[2] = 128'h0000312100001e430000aa2300001111;
    run_cmd(8'h01, 5'd1, 5'd2, 5'd3, 3, 1'b1, 1'b0, "vmul");
    chk("vmul_spec_result", last_wr, 128'h096da641_0393c589_711280c9_01234321);

    // vdot: three operands
    mem[3] = 128'h22221111222211112222111122221111;
    run_cmd(8'h02, 5'd1, 5'd2, 5'd3, 2, 1'b0, 1'b0, "vdot");
    chk("vdot_spec_result", last_wr, 128'h2b8fb752_25b5d69a_933491da_23455432);

    // reset during WB, then a normal command
    run_cmd(8'h01, 5'd5, 5'd6, 5'd7, 2, 1'b0, 1'b1, "abort");
    run_cmd(8'h03, 5'd8, 5'd9, 5'd10, 1, 1'b0, 1'b0, "after_abort");

    // same source register (bypass-dependent read count)
    run_cmd(8'h03, 5'd4, 5'd4, 5'd11, 2, 1'b0, 1'b0, "same_reg");

    // destination aliases a source
    run_cmd(8'h05, 5'd12, 5'd13, 5'd12, 4, 1'b1, 1'b0, "vd_alias");

    // random commands
    for (int t = 0; t < 8; t++) begin
      r1 = 5'($urandom_range(1, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(1, 31));
      rd = ($urandom_range(0, 3) == 0) ? r2 : 5'($urandom_range(1, 31));
      run_cmd(ops[$urandom_range(0, 4)], r1, r2, rd, int'($urandom_range(1, 5)),
              1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
